// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, default
// timing constants and the counter-width helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        ENABLE    = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam int DEF_N_OUT            = 3;
    localparam int DEF_RST_HOLD_CYC     = 50;
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_STAGGER_CYC      = 16;
    localparam int DEF_RETRY_MAX        = 3;

    // Width that holds every terminal count, including the value itself.
    function automatic int cnt_w(input int a, input int b, input int c, input int d);
        int w;
        w = 1;
        if ($clog2(a + 1) > w) w = $clog2(a + 1);
        if ($clog2(b + 1) > w) w = $clog2(b + 1);
        if ($clog2(c + 1) > w) w = $clog2(c + 1);
        if ($clog2(d + 1) > w) w = $clog2(d + 1);
        return w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer for a level signal crossing into clk.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer: pulses the PLL reset, qualifies lock, then
// staggers the forwarded-clock enables; retries on timeout and faults when exhausted.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int N_OUT            = DEF_N_OUT,
    parameter int RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int STAGGER_CYC      = DEF_STAGGER_CYC,
    parameter int RETRY_MAX        = DEF_RETRY_MAX
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               locked,
    input  logic                               restart,
    output logic                               pll_rst,
    output logic [N_OUT-1:0]                   out_en,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(RETRY_MAX+1)-1:0]     retry_cnt,
    output logic [7:0]                         lock_loss_cnt
);

    localparam int RW    = $clog2(RETRY_MAX + 1);
    localparam int CNT_W = cnt_w(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC,
                                 (N_OUT - 1) * STAGGER_CYC);

    // The cycle that first sees locked_s in WAIT_LOCK counts as stable cycle one,
    // hence the -2 on the stability terminal count.
    localparam logic [CNT_W-1:0] HOLD_END    = CNT_W'(RST_HOLD_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_END  = CNT_W'(LOCK_STABLE_CYC - 2);
    localparam logic [CNT_W-1:0] ENABLE_END  = CNT_W'((N_OUT - 1) * STAGGER_CYC);
    localparam logic [RW-1:0]    RETRY_LIM   = RW'(RETRY_MAX);

    logic              locked_s;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [7:0]        lock_loss_q, lock_loss_d;
    logic              pll_rst_q, pll_rst_d;
    logic [N_OUT-1:0]  out_en_q, out_en_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;
    logic [N_OUT-1:0]  enable_mask;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_locked (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (locked_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        retry_d     = retry_q;
        lock_loss_d = lock_loss_q;
        if (restart) begin
            state_d = RST_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                RST_PLL: begin
                    if (cnt_q == HOLD_END) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_END) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_LIM) begin
                            state_d = FAULT;
                        end else begin
                            state_d = RST_PLL;
                            retry_d = retry_q + 1'b1;
                        end
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_END) begin
                        state_d = ENABLE;
                        cnt_d   = '0;
                    end
                end
                ENABLE, RUN: begin
                    if (!locked_s) begin
                        state_d = RST_PLL;
                        cnt_d   = '0;
                        if (lock_loss_q != 8'hFF) lock_loss_d = lock_loss_q + 8'd1;
                    end else if (state_q == RUN) begin
                        cnt_d = '0;
                    end else if (cnt_q == ENABLE_END) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                FAULT: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = RST_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Bit gi of the stagger mask turns on once gi*STAGGER_CYC cycles have elapsed in ENABLE.
    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_stagger
            assign enable_mask[gi] = (32'(cnt_d) >= 32'(gi * STAGGER_CYC));
        end
    endgenerate

    always_comb begin
        pll_rst_d = (state_d == RST_PLL) || (state_d == FAULT);
        fault_d   = (state_d == FAULT);
        ready_d   = (state_d == RUN);
        out_en_d  = '0;
        if (state_d == RUN) begin
            out_en_d = '1;
        end else if (state_d == ENABLE) begin
            out_en_d = enable_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RST_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            lock_loss_q <= '0;
            pll_rst_q   <= 1'b1;
            out_en_q    <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lock_loss_q <= lock_loss_d;
            pll_rst_q   <= pll_rst_d;
            out_en_q    <= out_en_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign out_en        = out_en_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = lock_loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: expectations are queued per absolute cycle
// (cycle 0 = first edge with rst_n high) and checked just after each rising edge.
module tb_pll_lock_sequencer;

    localparam int S_RST  = 0;
    localparam int S_EN   = 1;
    localparam int S_RDY  = 2;
    localparam int S_FLT  = 3;
    localparam int S_RTY  = 4;
    localparam int S_LOSS = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic [2:0] out_en;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       tag;
    } sb_item_t;

    sb_item_t sb[$];
    int cyc = -1;
    int tests = 0;
    int fails = 0;

    pll_lock_sequencer #(
        .N_OUT            (3),
        .RST_HOLD_CYC     (4),
        .LOCK_TIMEOUT_CYC (20),
        .LOCK_STABLE_CYC  (8),
        .STAGGER_CYC      (2),
        .RETRY_MAX        (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .locked        (locked),
        .restart       (restart),
        .pll_rst       (pll_rst),
        .out_en        (out_en),
        .ready         (ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : -1;

    function automatic logic [31:0] obs_of(input int sel);
        logic [31:0] r;
        r = '0;
        case (sel)
            S_RST:   r[0]   = pll_rst;
            S_EN:    r[2:0] = out_en;
            S_RDY:   r[0]   = ready;
            S_FLT:   r[0]   = fault;
            S_RTY:   r[1:0] = retry_cnt;
            S_LOSS:  r[7:0] = lock_loss_cnt;
            default: r      = 32'hDEAD_BEEF;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        sb_item_t    item;
        logic [31:0] got;
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            item = sb.pop_front();
            got  = obs_of(item.sel);
            tests++;
            assert (got === item.val) else begin
                fails++;
                $error("FAIL %s @cyc %0d: observed %0h expected %0h", item.tag, item.cyc, got, item.val);
            end
        end
    end

    task automatic expect_at(input int c, input int sel, input logic [31:0] v, input string tag);
        sb_item_t it;
        it.cyc = c;
        it.sel = sel;
        it.val = v;
        it.tag = tag;
        sb.push_back(it);
    endtask

    task automatic expect_reset_vals();
        expect_at(-1, S_RST,  1, "reset pll_rst");
        expect_at(-1, S_EN,   0, "reset out_en");
        expect_at(-1, S_RDY,  0, "reset ready");
        expect_at(-1, S_FLT,  0, "reset fault");
        expect_at(-1, S_RTY,  0, "reset retry_cnt");
        expect_at(-1, S_LOSS, 0, "reset lock_loss_cnt");
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n   = 1'b0;
        locked  = 1'b0;
        restart = 1'b0;
        expect_reset_vals();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int c);
        int n = 0;
        while (cyc != c && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != c) begin
            tests++;
            fails++;
            $error("FAIL wait_cyc: observed cyc %0d expected %0d", cyc, c);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL drain: observed %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Normal bring-up
        reset_dut();
        expect_at(3,  S_RST, 1, "bringup pll_rst high");
        expect_at(4,  S_RST, 0, "bringup pll_rst low");
        expect_at(19, S_EN,  0, "bringup out_en pre");
        expect_at(20, S_EN,  1, "bringup out_en 001");
        expect_at(21, S_EN,  1, "bringup out_en hold");
        expect_at(22, S_EN,  3, "bringup out_en 011");
        expect_at(23, S_EN,  3, "bringup out_en hold2");
        expect_at(24, S_EN,  7, "bringup out_en 111");
        expect_at(24, S_RDY, 0, "bringup ready pre");
        expect_at(25, S_RDY, 1, "bringup ready");
        expect_at(25, S_RTY, 0, "bringup retry_cnt");
        expect_at(25, S_EN,  7, "bringup out_en run");
        wait_cyc(10); locked = 1'b1;
        drain();

        // Lock glitch in STABLE
        reset_dut();
        expect_at(20, S_EN,  0, "glitch no out_en 20");
        expect_at(25, S_EN,  0, "glitch no out_en 25");
        expect_at(26, S_EN,  1, "glitch out_en 001");
        expect_at(28, S_EN,  3, "glitch out_en 011");
        expect_at(30, S_EN,  7, "glitch out_en 111");
        expect_at(30, S_RDY, 0, "glitch ready pre");
        expect_at(31, S_RDY, 1, "glitch ready");
        wait_cyc(10); locked = 1'b1;
        wait_cyc(15); locked = 1'b0;
        wait_cyc(16); locked = 1'b1;
        drain();

        // Timeout / retry / fault / restart
        reset_dut();
        expect_at(23, S_RST, 0, "retry pll_rst low 23");
        expect_at(23, S_RTY, 0, "retry cnt 0");
        expect_at(24, S_RST, 1, "retry pulse2 start");
        expect_at(24, S_RTY, 1, "retry cnt 1");
        expect_at(28, S_RST, 1, "retry pulse2 hold");
        expect_at(29, S_RST, 0, "retry pulse2 end");
        expect_at(48, S_RTY, 1, "retry cnt 1 hold");
        expect_at(49, S_RST, 1, "retry pulse3 start");
        expect_at(49, S_RTY, 2, "retry cnt 2");
        expect_at(54, S_RST, 0, "retry pulse3 end");
        expect_at(73, S_FLT, 0, "fault pre");
        expect_at(73, S_RST, 0, "fault pre pll_rst");
        expect_at(74, S_FLT, 1, "fault set");
        expect_at(74, S_RST, 1, "fault pll_rst");
        expect_at(74, S_EN,  0, "fault out_en");
        expect_at(74, S_RTY, 2, "fault retry_cnt");
        expect_at(90, S_FLT, 1, "fault held");
        expect_at(90, S_RST, 1, "fault pll_rst held");
        expect_at(96, S_FLT, 0, "restart clears fault");
        expect_at(96, S_RTY, 0, "restart clears retry");
        expect_at(96, S_RST, 1, "restart pll_rst");
        expect_at(101, S_RST, 0, "restart pll_rst low");
        wait_cyc(95); restart = 1'b1;
        wait_cyc(96); restart = 1'b0;
        drain();

        // Lock loss in RUN, then restart/lock-drop priority, then reset in ENABLE
        reset_dut();
        expect_at(25, S_RDY,  1, "loss ready first");
        expect_at(32, S_EN,   7, "loss out_en pre");
        expect_at(32, S_RDY,  1, "loss ready pre");
        expect_at(32, S_LOSS, 0, "loss cnt pre");
        expect_at(33, S_EN,   0, "loss out_en drop");
        expect_at(33, S_RDY,  0, "loss ready drop");
        expect_at(33, S_LOSS, 1, "loss cnt 1");
        expect_at(33, S_RST,  1, "loss pll_rst");
        expect_at(38, S_RST,  0, "loss pll_rst low");
        expect_at(49, S_EN,   0, "relock out_en pre");
        expect_at(50, S_EN,   1, "relock out_en 001");
        expect_at(52, S_EN,   3, "relock out_en 011");
        expect_at(54, S_EN,   7, "relock out_en 111");
        expect_at(55, S_RDY,  1, "relock ready");
        expect_at(55, S_LOSS, 1, "relock loss cnt");
        expect_at(55, S_RTY,  0, "relock retry_cnt");
        expect_at(62, S_EN,   7, "prio out_en pre");
        expect_at(62, S_LOSS, 1, "prio loss pre");
        expect_at(63, S_EN,   0, "prio out_en clr");
        expect_at(63, S_RDY,  0, "prio ready clr");
        expect_at(63, S_LOSS, 1, "prio loss kept");
        expect_at(63, S_RST,  1, "prio pll_rst");
        expect_at(63, S_RTY,  0, "prio retry_cnt");
        expect_at(68, S_RST,  0, "prio pll_rst low");
        expect_at(70, S_LOSS, 1, "prio loss still");
        expect_at(80, S_EN,   1, "enable2 out_en 001");
        expect_at(82, S_EN,   3, "enable2 out_en 011");
        wait_cyc(10); locked = 1'b1;
        wait_cyc(30); locked = 1'b0;
        wait_cyc(40); locked = 1'b1;
        wait_cyc(60); locked = 1'b0;
        wait_cyc(62); restart = 1'b1;
        wait_cyc(63); restart = 1'b0;
        wait_cyc(70); locked = 1'b1;
        wait_cyc(82);
        rst_n = 1'b0;
        expect_reset_vals();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
